pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Sequences the fetch PC register. Each cycle it chooses the next PC, drives the register's
//   data and enable inputs, and decides when the pipeline is flushed.
//   Next-PC sources: sequential, D-stage branch/jump redirect, exception/interrupt entry, eret return.
//   Owns EPC, the EXL (in-handler) flag, the BD flag and the interrupt-wait FSM.
//   Sits between hazard unit, D-stage control, M-stage exception logic and the PC register.
// PARAMETERS
//   RESET_PC    32'h0000_3000  PC value driven while reset is high
//   HANDLER_PC  32'h0000_4180  exception/interrupt entry vector
//   IMEM_LO     32'h0000_3000  lowest legal fetch address
//   IMEM_HI     32'h0000_4FFC  highest legal fetch address
// PORTS
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous, active-high
//   pc_cur_i         in   32  current fetch PC (PC register output)
//   pc_next_o        out  32  next PC -> PC register data input
//   pc_en_o          out  1   PC register write enable
//   stall_i          in   1   hazard stall of F/D
//   d_redirect_i     in   1   D-stage branch taken / j / jal / jr
//   d_target_i       in   32  redirect target
//   exc_i            in   1   synchronous exception reported by M stage
//   eret_i           in   1   eret in M stage
//   m_valid_i        in   1   M stage holds a real (non-bubble) instruction
//   m_pc_i           in   32  PC of M-stage instruction
//   m_bd_i           in   1   M-stage instruction is in a delay slot
//   hwint_i          in   6   hardware interrupt lines
//   im_i             in   6   interrupt mask (from SR)
//   ie_i             in   1   global interrupt enable (from SR)
//   flush_o          out  1   flush F/D, D/E, E/M pipeline registers this cycle
//   trap_o           out  1   exception/interrupt taken this cycle (CP0 capture strobe)
//   epc_o            out  32  exception PC
//   exl_o            out  1   in-handler flag
//   bd_o             out  1   Cause.BD
//   fetch_adel_o     out  1   pc_cur_i misaligned or outside [IMEM_LO, IMEM_HI]
// BEHAVIOUR
//   Signal definitions:
//   - irq  = |(hwint_i & im_i) & ie_i & !exl.
//   - take = exc_i | (irq & m_valid_i).
//   Next-PC priority, all combinational, same cycle:
//   - reset:      pc_next=RESET_PC, en=1, flush=1.
//   - take:       pc_next=HANDLER_PC, en=1, flush=1, trap=1. Overrides stall.
//   - eret_i:     pc_next=epc, en=1, flush=1. Overrides stall.
//   - stall_i:    en=0, pc_next=pc_cur_i, flush=0.
//   - d_redirect: pc_next=d_target_i, en=1.
//   - otherwise:  pc_next=pc_cur_i+4 (mod 2^32), en=1.
//   FSM states RUN, IRQ_WAIT, HANDLER; all transitions on clk edge:
//   - RUN -> IRQ_WAIT: irq && !m_valid_i (bubble in M). Interrupt is deferred, never dropped.
//   - IRQ_WAIT -> HANDLER: irq && m_valid_i (take fires).
//   - IRQ_WAIT -> RUN: irq deasserts before taken.
//   - RUN/IRQ_WAIT -> HANDLER: take.
//   - HANDLER -> RUN: eret_i.
//   - exc_i in HANDLER: redirect to HANDLER_PC and flush; EPC/BD not updated; stays HANDLER.
//   On take with exl=0 (registered at edge):
//   - epc <= m_bd_i ? m_pc_i-4 : m_pc_i, with bits [1:0] forced to 0.
//   - bd <= m_bd_i; exl <= 1.
//   - eret_i: exl <= 0 at the edge; redirect uses old epc.
//   - eret_i with exl=0: still redirects to epc; exl stays 0.
//   - take and eret_i in same cycle: take wins; eret is flushed.
//   Reset values: epc=0, bd=0, exl=0, state=RUN.
//   - While reset: pc_next_o=RESET_PC, pc_en_o=1, flush_o=1, trap_o=0.
//   - Reset mid-handler returns to RUN with exl=0.
//   fetch_adel_o is combinational on pc_cur_i:
//   - pc_cur_i[1:0]!=0 OR pc_cur_i<IMEM_LO OR pc_cur_i>IMEM_HI.
// STRUCTURE
//   Shared package: RESET_PC, HANDLER_PC, IMEM_LO/HI, FSM state encoding (2-bit), ExcCode Int=0, AdEL=4.
//   One sub-module, pc_next_mux: purely combinational priority select of pc_next_o/pc_en_o/flush_o.
//   FSM, EPC/EXL/BD registers stay in pc_sequencer.
// TESTING
//   1. Reset 3 cycles, release, no events
//      -> pc_next 3000,3004,3008; en=1; flush=0 after reset.
//   2. stall_i=1 for 2 cycles at pc 300C
//      -> en=0, pc_next=300C; then d_redirect to 3400 next cycle -> pc_next=3400.
//   3. exc_i with m_pc=3010, m_bd=1, stall_i=1 in same cycle
//      -> pc_next=4180, en=1, flush=1, trap=1; next cycle epc=300C, bd=1, exl=1.
//   4. hwint=000100, im=000100, ie=1, m_valid=0 for 2 cycles, then m_valid=1, m_pc=3020
//      -> IRQ_WAIT held, no trap; then trap, epc=3020.
//   5. In HANDLER: irq asserted -> ignored (exl=1).
//      Then eret_i -> pc_next=epc, flush=1, exl=0, state RUN.
//   6. pc_cur_i=3002 and pc_cur_i=5000 -> fetch_adel_o=1; pc_cur_i=4FFC -> 0.
//      pc_cur_i=FFFFFFFC with no events -> pc_next=00000000 (wrap).

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-PC sequencer slice.
//   - Default address map: reset PC, exception entry vector, legal fetch window.
//   - FSM state encoding for the interrupt-wait machine.
//   - CP0 ExcCode values used by the exception logic around this block.
//   - Helper functions for EPC formation and fetch-address legality.
package pc_sequencer_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI    = 32'h0000_4FFC;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_IRQ_WAIT = 2'd1,
        ST_HANDLER  = 2'd2
    } seq_state_e;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] v;
        v = bd ? (pc - 32'd4) : pc;
        return {v[31:2], 2'b00};
    endfunction

    function automatic logic fetch_bad(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of all pc_sequencer pipeline-facing signals.
//   master : the surrounding pipeline (drives the *_i signals, observes *_o)
//   slave  : pc_sequencer itself
// Signal names keep the original port names of the sequencer.
interface pc_sequencer_if;

    logic [31:0] pc_cur_i;
    logic [31:0] pc_next_o;
    logic        pc_en_o;
    logic        stall_i;
    logic        d_redirect_i;
    logic [31:0] d_target_i;
    logic        exc_i;
    logic        eret_i;
    logic        m_valid_i;
    logic [31:0] m_pc_i;
    logic        m_bd_i;
    logic [5:0]  hwint_i;
    logic [5:0]  im_i;
    logic        ie_i;
    logic        flush_o;
    logic        trap_o;
    logic [31:0] epc_o;
    logic        exl_o;
    logic        bd_o;
    logic        fetch_adel_o;

    modport master (
        output pc_cur_i, stall_i, d_redirect_i, d_target_i, exc_i, eret_i,
               m_valid_i, m_pc_i, m_bd_i, hwint_i, im_i, ie_i,
        input  pc_next_o, pc_en_o, flush_o, trap_o, epc_o, exl_o, bd_o,
               fetch_adel_o
    );

    modport slave (
        input  pc_cur_i, stall_i, d_redirect_i, d_target_i, exc_i, eret_i,
               m_valid_i, m_pc_i, m_bd_i, hwint_i, im_i, ie_i,
        output pc_next_o, pc_en_o, flush_o, trap_o, epc_o, exl_o, bd_o,
               fetch_adel_o
    );

endinterface

// File: rtl/pc_sequencer_next_mux.sv
// pc_next_mux: purely combinational priority select of the next fetch PC.
// Priority (highest first): reset, take, eret, stall, D-stage redirect,
// sequential (+4, wrapping modulo 2^32).
// Ports:
//   i_reset, i_take, i_eret, i_stall, i_redirect : selection conditions
//   i_target  : D-stage redirect target
//   i_epc     : return address for eret
//   i_pc_cur  : current fetch PC
//   o_pc_next : PC register data input
//   o_pc_en   : PC register write enable
//   o_flush   : flush F/D, D/E, E/M this cycle
module pc_next_mux #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        i_reset,
    input  logic        i_take,
    input  logic        i_eret,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_pc_cur,
    output logic [31:0] o_pc_next,
    output logic        o_pc_en,
    output logic        o_flush
);

    always_comb begin
        o_pc_next = i_pc_cur + 32'd4;
        o_pc_en   = 1'b1;
        o_flush   = 1'b0;
        if (i_reset) begin
            o_pc_next = RESET_PC;
            o_flush   = 1'b1;
        end else if (i_take) begin
            o_pc_next = HANDLER_PC;
            o_flush   = 1'b1;
        end else if (i_eret) begin
            o_pc_next = i_epc;
            o_flush   = 1'b1;
        end else if (i_stall) begin
            o_pc_next = i_pc_cur;
            o_pc_en   = 1'b0;
        end else if (i_redirect) begin
            o_pc_next = i_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: chooses the next fetch PC each cycle, drives the PC register
// data/enable, decides pipeline flushes, and owns EPC, EXL, BD and the
// interrupt-wait FSM.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : pc_sequencer_if.slave -- PC register, hazard, D-stage and
//           M-stage exception/interrupt signals (see interface file)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] IMEM_LO    = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI    = DEF_IMEM_HI
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    seq_state_e  r_state;
    seq_state_e  w_state_next;
    logic [31:0] r_epc;
    logic        r_exl;
    logic        r_bd;
    logic        w_irq;
    logic        w_take;

    // Interrupts are masked while in the handler; a pending interrupt is only
    // taken against a real instruction in M so EPC points at something valid.
    assign w_irq  = (|(bus.hwint_i & bus.im_i)) & bus.ie_i & ~r_exl;
    assign w_take = bus.exc_i | (w_irq & bus.m_valid_i);

    pc_next_mux #(
        .RESET_PC   (RESET_PC),
        .HANDLER_PC (HANDLER_PC)
    ) u_next_mux (
        .i_reset    (reset),
        .i_take     (w_take),
        .i_eret     (bus.eret_i),
        .i_stall    (bus.stall_i),
        .i_redirect (bus.d_redirect_i),
        .i_target   (bus.d_target_i),
        .i_epc      (r_epc),
        .i_pc_cur   (bus.pc_cur_i),
        .o_pc_next  (bus.pc_next_o),
        .o_pc_en    (bus.pc_en_o),
        .o_flush    (bus.flush_o)
    );

    assign bus.trap_o       = w_take & ~reset;
    assign bus.epc_o        = r_epc;
    assign bus.exl_o        = r_exl;
    assign bus.bd_o         = r_bd;
    assign bus.fetch_adel_o = fetch_bad(bus.pc_cur_i, IMEM_LO, IMEM_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_take) begin
                    w_state_next = ST_HANDLER;
                end else if (w_irq && !bus.m_valid_i) begin
                    w_state_next = ST_IRQ_WAIT;
                end
            end
            ST_IRQ_WAIT: begin
                if (w_take) begin
                    w_state_next = ST_HANDLER;
                end else if (!w_irq) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HANDLER: begin
                // A take in the handler (exception) keeps us here; eret only
                // leaves when it is not itself being flushed by a take.
                if (bus.eret_i && !w_take) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_epc <= '0;
            r_bd  <= 1'b0;
            r_exl <= 1'b0;
        end else if (w_take && !r_exl) begin
            r_epc <= epc_of(bus.m_pc_i, bus.m_bd_i);
            r_bd  <= bus.m_bd_i;
            r_exl <= 1'b1;
        end else if (bus.eret_i && !w_take) begin
            r_exl <= 1'b0;
        end
    end

endmodule
